// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Sizes follow the funct3 layout: [1:0] is the width, [2] selects zero extension.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int         SZ_UNSIGNED_BIT = 2;

  localparam logic [3:0] OFF_TOHOST   = 4'h0;
  localparam logic [3:0] OFF_CYCLE_LO = 4'h4;
  localparam logic [3:0] OFF_CYCLE_HI = 4'h8;

  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_MMIO} rd_src_e;

  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] a);
    case (size[1:0])
      SZ_B:    return 1'b1;
      SZ_H:    return ~a[0];
      SZ_W:    return (a == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byteEnable(input logic [2:0] size, input logic [1:0] a);
    case (size[1:0])
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] loadFormat(input logic [31:0] word, input logic [1:0] a,
                                             input logic [2:0] size);
    logic [31:0] sh;
    logic        uns;
    sh  = word >> {a, 3'b000};
    uns = size[SZ_UNSIGNED_BIT];
    case (size[1:0])
      SZ_B:    return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_W:    return word;
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side dmem port: the core is master, the responder is slave.
interface dmem_if;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [2:0]  dmemSize;
  logic        dmemWen;
  logic        dmemRen;
  logic [31:0] dmemRdata;

  modport master (output dmemAddr, dmemWdata, dmemSize, dmemWen, dmemRen, input dmemRdata);
  modport slave  (input dmemAddr, dmemWdata, dmemSize, dmemWen, dmemRen, output dmemRdata);
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
module dmem_ram #(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: the array has no reset branch; resetting it would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem slave: byte-steered RAM, tohost mailbox and a 64-bit cycle counter whose
// high word is snapshotted on every CYCLE_LO load so LO/HI pairs read coherently.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
  parameter logic [63:0] CYCLE_PRESET = 64'd0  // counter value after reset; 0 in silicon
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus,
  output logic        tohostValid,
  output logic [31:0] tohostData,
  output logic        accessErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic        w_mmio, w_legal, w_load, w_store, w_ram_we, w_ram_re, w_tohost_wr;
  logic [3:0]  w_off, w_be;
  logic [31:0] w_wdata, w_mmio_rdata, w_ram_rdata;

  logic [63:0] r_cycle;
  logic [31:0] r_hi_snap, r_tohost, r_mmio_q;
  logic        r_tohost_valid, r_err;
  rd_src_e     r_src;
  logic [1:0]  r_lane;
  logic [2:0]  r_size;

  assign w_mmio      = (bus.dmemAddr[31:28] == MMIO_BASE[31:28]);
  assign w_off       = bus.dmemAddr[3:0];
  assign w_legal     = size_aligned(bus.dmemSize, bus.dmemAddr[1:0]) &&
                       (!w_mmio || bus.dmemSize[1:0] == SZ_W);
  // A store wins over a simultaneous load; the load is simply dropped.
  assign w_load      = bus.dmemRen && !bus.dmemWen && w_legal;
  assign w_store     = bus.dmemWen && w_legal;
  assign w_ram_we    = w_store && !w_mmio;
  assign w_ram_re    = w_load && !w_mmio && !rst;
  assign w_tohost_wr = w_store && w_mmio && (w_off == OFF_TOHOST);
  assign w_be        = byteEnable(bus.dmemSize, bus.dmemAddr[1:0]);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_wdata = bus.dmemWdata;
    if (bus.dmemSize[1:0] == SZ_B)      w_wdata = {4{bus.dmemWdata[7:0]}};
    else if (bus.dmemSize[1:0] == SZ_H) w_wdata = {2{bus.dmemWdata[15:0]}};
  end

  always_comb begin
    w_mmio_rdata = 32'b0;
    case (w_off)
      OFF_TOHOST:   w_mmio_rdata = r_tohost;
      OFF_CYCLE_LO: w_mmio_rdata = r_cycle[31:0];
      OFF_CYCLE_HI: w_mmio_rdata = r_hi_snap;
      default:      w_mmio_rdata = 32'b0;
    endcase
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_be    (w_be),
    .i_re    (w_ram_re),
    .i_addr  (bus.dmemAddr[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle        <= CYCLE_PRESET;
      r_hi_snap      <= 32'b0;
      r_tohost       <= 32'b0;
      r_tohost_valid <= 1'b0;
      r_err          <= 1'b0;
      r_mmio_q       <= 32'b0;
      r_src          <= SRC_NONE;
    end else begin
      r_cycle        <= r_cycle + 64'd1;
      r_tohost_valid <= w_tohost_wr;
      if (w_tohost_wr) r_tohost <= bus.dmemWdata;
      if ((bus.dmemWen || bus.dmemRen) && !w_legal) r_err <= 1'b1;
      if (bus.dmemRen && !bus.dmemWen) begin
        if (!w_legal) begin
          r_src <= SRC_NONE;
        end else if (w_mmio) begin
          r_src    <= SRC_MMIO;
          r_mmio_q <= w_mmio_rdata;
          if (w_off == OFF_CYCLE_LO) r_hi_snap <= r_cycle[63:32];
        end else begin
          r_src <= SRC_RAM;
        end
      end
    end
  end

  // Lane and size are only consumed when r_src says RAM, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_ram_re) begin
      r_lane <= bus.dmemAddr[1:0];
      r_size <= bus.dmemSize;
    end
  end

  always_comb begin
    bus.dmemRdata = 32'b0;
    case (r_src)
      SRC_RAM:  bus.dmemRdata = loadFormat(w_ram_rdata, r_lane, r_size);
      SRC_MMIO: bus.dmemRdata = r_mmio_q;
      default:  bus.dmemRdata = 32'b0;
    endcase
  end

  assign tohostValid = r_tohost_valid;
  assign tohostData  = r_tohost;
  assign accessErr   = r_err;

endmodule
